// File: rtl/pxs_window_capture_pkg.sv
// Pxs stream package: word layout, colours, state type and frame predicates.
// Shared by pxs_window_capture and its testbench-facing helpers.
package pxs_window_capture_pkg;

  localparam int PX_W = 26;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [9:0] xc;
    logic [9:0] yc;
    logic       act;
    logic [2:0] rgb;
  } px_t;

  localparam logic [2:0] PX_BLACK = 3'b000;
  localparam logic [2:0] PX_BLUE  = 3'b001;
  localparam logic [2:0] PX_GREEN = 3'b010;
  localparam logic [2:0] PX_RED   = 3'b100;
  localparam logic [2:0] PX_WHITE = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } cap_state_t;

  function automatic logic px_sof(input px_t p);
    return p.act && (p.xc == '0) && (p.yc == '0);
  endfunction

  function automatic logic px_eof(input px_t p,
                                  input int  cols,
                                  input int  rows);
    return p.act && (p.xc == 10'(cols - 1))
                 && (p.yc == 10'(rows - 1));
  endfunction

endpackage

// File: rtl/pxs_capture_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data register clears on reset; array contents do not.
module pxs_capture_ram #(
  parameter  int DEPTH = 7680,
  parameter  int WIDTH = 3,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pxs_window_capture.sv
// Inline Pxs sink grabbing a window of one full frame into a buffer.
// Define PXS_CAPTURE_DECIM2_EN for 2x decimated capture.
module pxs_window_capture
  import pxs_window_capture_pkg::*;
#(
  parameter  int WIN_W       = 96,
  parameter  int WIN_H       = 80,
  parameter  int VISIBLECOLS = 640,
  parameter  int VISIBLEROWS = 480,
  localparam int AW          = $clog2(WIN_W * WIN_H)
) (
  input  logic          px_clk,
  input  logic          px_rst,
  input  logic [25:0]   RGBStr_i,
  output logic [25:0]   RGBStr_o,
  input  logic [9:0]    x0_i,
  input  logic [9:0]    y0_i,
  input  logic          arm_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW:0]   wr_count_o,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [2:0]    rd_data_o
);

  localparam int DEPTH = WIN_W * WIN_H;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

`ifdef PXS_CAPTURE_DECIM2_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif

  localparam logic [10:0] SPAN_X = 11'(SC * WIN_W);
  localparam logic [10:0] SPAN_Y = 11'(SC * WIN_H);

  px_t        pin;
  cap_state_t state, nxt;

  logic          arm_take, cap_en, we;
  logic          in_x, in_y, keep;
  logic [9:0]    x0_q, y0_q;
  logic [10:0]   x11, y11, xs, ys;
  logic [10:0]   dx, dy, col, key, last_key;
  logic          row_seen;
  logic [AW-1:0] row_base, base_now, wr_addr;
  logic [AW:0]   cnt;

  assign pin = px_t'(RGBStr_i);

  assign x11 = {1'b0, pin.xc};
  assign y11 = {1'b0, pin.yc};
  assign xs  = {1'b0, x0_q};
  assign ys  = {1'b0, y0_q};
  assign dx  = x11 - xs;
  assign dy  = y11 - ys;

  assign in_x = (x11 >= xs) && (x11 < xs + SPAN_X);
  assign in_y = (y11 >= ys) && (y11 < ys + SPAN_Y);

`ifdef PXS_CAPTURE_DECIM2_EN
  assign keep = ~dx[0] & ~dy[0];
  assign col  = dx >> 1;
  assign key  = dy >> 1;
`else
  assign keep = 1'b1;
  assign col  = dx;
  assign key  = dy;
`endif

  always_comb begin
    nxt      = state;
    arm_take = 1'b0;
    cap_en   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (arm_i) begin
          arm_take = 1'b1;
          nxt      = S_ARMED;
        end
      end
      S_ARMED: begin
        if (px_sof(pin)) begin
          cap_en = 1'b1;
          nxt    = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        cap_en = 1'b1;
        if (px_eof(pin, VISIBLECOLS, VISIBLEROWS)) nxt = S_DONE;
      end
      S_DONE: begin
        if (arm_i) begin
          arm_take = 1'b1;
          nxt      = S_ARMED;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (px_rst) state <= S_IDLE;
    else        state <= nxt;
  end

  assign we = cap_en && !px_rst && pin.act && in_x && in_y && keep;

  // Row base moves by one stored row on the first write of each new row.
  always_comb begin
    base_now = row_base;
    if (!row_seen)            base_now = '0;
    else if (key != last_key) base_now = row_base + AW'(WIN_W);
  end

  assign wr_addr = base_now + AW'(col);

  always_ff @(posedge px_clk) begin
    if (px_rst) begin
      RGBStr_o <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      cnt      <= '0;
      row_base <= '0;
      last_key <= '0;
      row_seen <= 1'b0;
    end else begin
      RGBStr_o <= pin;
      if (arm_take) begin
        x0_q     <= x0_i;
        y0_q     <= y0_i;
        cnt      <= '0;
        row_base <= '0;
        row_seen <= 1'b0;
      end else if (we) begin
        row_base <= base_now;
        last_key <= key;
        row_seen <= 1'b1;
        if (cnt != FULL) cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy_o     = (state == S_ARMED) || (state == S_CAPTURE);
  assign done_o     = (state == S_DONE);
  assign wr_count_o = cnt;

  pxs_capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (3)
  ) u_ram (
    .clk   (px_clk),
    .rst   (px_rst),
    .we    (we),
    .waddr (wr_addr),
    .wdata (pin.rgb),
    .re    (rd_en_i),
    .raddr (rd_addr_i),
    .rdata (rd_data_o)
  );

endmodule

// File: tb/tb_pxs_window_capture.sv
// Directed bench for pxs_window_capture with hand-computed expectations.
// Stream word: {HS, VS, XC[9:0], YC[9:0], Active, RGB[2:0]}.
module tb_pxs_window_capture;

  logic        px_clk = 1'b0;
  logic        px_rst;
  logic [25:0] RGBStr_i;
  logic [25:0] RGBStr_o;
  logic [9:0]  x0_i;
  logic [9:0]  y0_i;
  logic        arm_i;
  logic        busy_o;
  logic        done_o;
  logic [13:0] wr_count_o;
  logic        rd_en_i;
  logic [12:0] rd_addr_i;
  logic [2:0]  rd_data_o;

  int total = 0;
  int bad   = 0;

  always #5 px_clk = ~px_clk;

  pxs_window_capture dut (
    .px_clk     (px_clk),
    .px_rst     (px_rst),
    .RGBStr_i   (RGBStr_i),
    .RGBStr_o   (RGBStr_o),
    .x0_i       (x0_i),
    .y0_i       (y0_i),
    .arm_i      (arm_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .wr_count_o (wr_count_o),
    .rd_en_i    (rd_en_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] pk(input logic act, input int x,
                                     input int y, input logic [2:0] c);
    return {2'b00, 10'(x), 10'(y), act, c};
  endfunction

  function automatic logic [2:0] pat(input int x, input int y);
    return 3'(x ^ y);
  endfunction

  task automatic step;
    @(posedge px_clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    RGBStr_i = pk(1'b1, x, y, pat(x, y));
    step();
  endtask

  task automatic rd(input string tag, input int a, input logic [2:0] exp);
    rd_en_i   = 1'b1;
    rd_addr_i = 13'(a);
    step();
    rd_en_i   = 1'b0;
    chk(tag, 32'(rd_data_o), 32'(exp));
  endtask

  initial begin
    logic [25:0] v;
    px_rst    = 1'b1;
    RGBStr_i  = '0;
    x0_i      = '0;
    y0_i      = '0;
    arm_i     = 1'b0;
    rd_en_i   = 1'b0;
    rd_addr_i = '0;
    step();
    RGBStr_i = pk(1'b1, 5, 5, 3'b101);
    step();
    chk("rst_str", 32'(RGBStr_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_cnt", 32'(wr_count_o), 0);
    chk("rst_rd", 32'(rd_data_o), 0);
    px_rst = 1'b0;

    for (int i = 0; i < 256; i++) begin
      v = 26'($urandom);
      RGBStr_i = v;
      step();
      chk("pass", 32'(RGBStr_o), 32'(v));
    end
    chk("pass_idle", 32'(busy_o), 0);

`ifdef PXS_CAPTURE_DECIM2_EN
    RGBStr_i = pk(1'b1, 300, 200, 3'b000);
    x0_i  = 10'd0;
    y0_i  = 10'd0;
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    chk("d_arm", 32'(busy_o), 1);
    for (int y = 0; y < 160; y++)
      for (int x = 0; x < 192; x++) pix(x, y);
    pix(639, 479);
    chk("d_done", 32'(done_o), 1);
    chk("d_cnt", 32'(wr_count_o), 7680);
    rd("d_a1", 1, 3'd2);
    rd("d_a3", 3, 3'd6);
    rd("d_a96", 96, 3'd2);
    rd("d_a192", 192, 3'd4);
`else
    RGBStr_i = pk(1'b1, 300, 200, 3'b000);
    x0_i  = 10'd100;
    y0_i  = 10'd50;
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    chk("g_busy", 32'(busy_o), 1);
    chk("g_done0", 32'(done_o), 0);
    x0_i  = 10'd5;
    arm_i = 1'b1;
    pix(120, 60);
    arm_i = 1'b0;
    chk("g_armed_cnt", 32'(wr_count_o), 0);
    chk("g_armed_busy", 32'(busy_o), 1);
    pix(0, 0);
    pix(99, 50);
    for (int x = 100; x < 196; x++) pix(x, 50);
    pix(196, 50);
    chk("g_row0", 32'(wr_count_o), 96);
    x0_i  = 10'd0;
    y0_i  = 10'd0;
    arm_i = 1'b1;
    pix(300, 50);
    arm_i = 1'b0;
    chk("g_arm_ign", 32'(wr_count_o), 96);
    for (int y = 51; y < 130; y++)
      for (int x = 100; x < 196; x++) pix(x, y);
    chk("g_pre_eof", 32'(done_o), 0);
    chk("g_full", 32'(wr_count_o), 7680);
    pix(639, 479);
    chk("g_done", 32'(done_o), 1);
    chk("g_idle", 32'(busy_o), 0);
    chk("g_cnt", 32'(wr_count_o), 7680);
    rd("g_a0", 0, 3'b110);
    rd("g_a7679", 7679, 3'b010);
    rd("g_a965", 965, 3'd5);

    RGBStr_i = pk(1'b0, 0, 0, 3'b000);
    x0_i  = 10'd600;
    y0_i  = 10'd440;
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    chk("c_rearm_busy", 32'(busy_o), 1);
    chk("c_rearm_done", 32'(done_o), 0);
    chk("c_rearm_cnt", 32'(wr_count_o), 0);
    pix(0, 0);
    for (int y = 440; y < 480; y++)
      for (int x = 600; x < 640; x++) pix(x, y);
    chk("c_done", 32'(done_o), 1);
    chk("c_cnt", 32'(wr_count_o), 1600);
    rd("c_a39", 39, 3'd7);
    rd("c_a40", 40, 3'd6);
    rd("c_a96", 96, 3'd1);

    RGBStr_i = pk(1'b0, 0, 0, 3'b000);
    x0_i  = 10'd0;
    y0_i  = 10'd0;
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    for (int y = 0; y < 60; y++)
      for (int x = 0; x < 96; x++) pix(x, y);
    chk("r_cnt_pre", 32'(wr_count_o), 5760);
    px_rst   = 1'b1;
    RGBStr_i = pk(1'b1, 0, 60, 3'b100);
    step();
    chk("r_busy", 32'(busy_o), 0);
    chk("r_done", 32'(done_o), 0);
    chk("r_cnt", 32'(wr_count_o), 0);
    chk("r_str", 32'(RGBStr_o), 0);
    px_rst   = 1'b0;
    RGBStr_i = pk(1'b1, 0, 0, 3'b000);
    step();
    chk("r_stay_idle", 32'(busy_o), 0);
    rd("r_a5000", 5000, 3'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pxs_window_capture.md
Name: pxs_window_capture

Overview:
- Pixel-stream sink that snapshots a rectangular window of one complete video frame into an on-chip buffer. The buffer has a host-side random read port.
- Inverse of the overlay blocks: those read a pattern memory and write it into the stream; this block reads the stream and writes the pattern memory.
- Sits inline in the Pxs chain and forwards the stream unmodified with 1-cycle latency.
- Used for frame grab, debug readback and golden-image comparison.

Parameters:
- WIN_W, 96, window width in stored pixels.
- WIN_H, 80, window height in stored pixels.
- VISIBLECOLS, 640, active columns per line.
- VISIBLEROWS, 480, active rows per frame.
- AW, $clog2(WIN_W*WIN_H), buffer address width (localparam).

Ports:
- px_clk  in  1  pixel clock; the only clock.
- px_rst  in  1  reset, synchronous, active-high.
- RGBStr_i  in  26  input pixel stream; fields per Pxs.vh (HS, VS, XC, YC, Active, RGB).
- RGBStr_o  out  26  RGBStr_i delayed exactly 1 cycle.
- x0_i  in  10  window upper-left X, sampled on arm.
- y0_i  in  10  window upper-left Y, sampled on arm.
- arm_i  in  1  single-cycle request to capture the next full frame.
- busy_o  out  1  high in ARMED or CAPTURE.
- done_o  out  1  high in DONE.
- wr_count_o  out  AW+1  pixels written in the current or last capture.
- rd_en_i  in  1  buffer read strobe.
- rd_addr_i  in  AW  buffer read address, row-major (y*WIN_W+x).
- rd_data_o  out  3  RGB at rd_addr_i, valid the cycle after rd_en_i.

Behaviour:
- Reset values: RGBStr_o=0, busy_o=0, done_o=0, wr_count_o=0, rd_data_o=0, state=IDLE. Buffer contents are not cleared.
- Stream pass-through: every field is registered once and unchanged, with or without a capture.
- Frame start (SOF): Active=1 and XC=0 and YC=0. Frame end (EOF): Active=1 and XC=VISIBLECOLS-1 and YC=VISIBLEROWS-1.
- FSM states:
  - IDLE: on arm_i, latch x0/y0, clear wr_count and write address, go to ARMED.
  - ARMED: wait for SOF. The SOF pixel itself is eligible for capture. Go to CAPTURE.
  - CAPTURE: write the pixel when Active=1 and x0 <= XC < x0+WIN_W and y0 <= YC < y0+WIN_H. On EOF (after its own write decision) go to DONE.
  - DONE: done_o=1. A new arm_i re-enters ARMED directly and clears done_o the next cycle.
- arm_i in ARMED or CAPTURE is ignored. No restart and no counter clear.
- Window compares are done in 11-bit unsigned arithmetic so x0+WIN_W cannot wrap.
- Write address is an incrementing counter, not a multiply. Pixels arrive in raster order, so addr = number of in-window pixels already written.
- Clipping: a window extending past VISIBLECOLS/VISIBLEROWS writes only visible pixels. The write address still advances row-major per stored row.
  - Implementation: address = row_base + (XC-x0). row_base += WIN_W at the first in-window pixel of each new row.
  - Entries off-screen keep stale data.
- wr_count_o increments per write and saturates at WIN_W*WIN_H. A fully visible window ends at exactly WIN_W*WIN_H.
- Buffer is a simple dual-port RAM, one write port and one read port, inferable to BRAM. 3-bit words may be packed into wider words.
- Reads are allowed in any state. A same-address read and write in the same cycle returns old or new data (unspecified).
- Reset mid-capture: return to IDLE next cycle. Buffer is partially written; done_o=0.

Optional Feature:
- Macro PXS_CAPTURE_DECIM2_EN.
- Defined: 2x decimation. The window spans 2*WIN_W x 2*WIN_H screen pixels. Only pixels with (XC-x0)[0]=0 and (YC-y0)[0]=0 are stored, at address ((YC-y0)>>1)*WIN_W+((XC-x0)>>1). Stored count is still WIN_W*WIN_H.
- Undefined: 1:1 capture as described above.

Decomposition:
- Shared Pxs package/header: stream field macros (HS, VS, XC, YC, Active, RGB), colour constants, and the SOF/EOF predicates (as macros/functions).
- One sub-module: pxs_capture_ram, a parameterized simple dual-port RAM (depth, width, registered read).
- The FSM, window compare and address counter stay in the top.

Test Plan:
- Pass-through: random stream, no arm -> RGBStr_o equals RGBStr_i delayed 1 cycle, bit-exact, for a whole frame.
- Basic grab: x0=100, y0=50, arm mid-frame; stream RGB=(XC^YC)[2:0] -> done after the next full EOF; wr_count=7680; rd_addr=0 returns 3'b110 (100^50=86, [2:0]=6); rd_addr=7679 (XC=195, YC=129) returns (195^129)[2:0]=3'b010.
- Clipping: x0=600, y0=440 -> wr_count=40*40=1600. Address 39 holds pixel (639,440). Address 40 is unchanged from its preload.
- Arm timing: arm during ARMED or CAPTURE -> ignored, wr_count is not reset. Arm in DONE -> busy next cycle, done_o low.
- Reset mid-capture: assert px_rst at YC=60 -> next cycle state IDLE, busy=0, done=0, wr_count=0, RGBStr_o=0.
- DECIM2_EN build: x0=0, y0=0 -> address 1 holds pixel (2,0); address 96 holds pixel (0,2); wr_count=7680.
